// File: rtl/sonic_pcs_pkg.sv
// Shared types and helpers for the SONIC PCS receive path.
package sonic_pcs_pkg;

    typedef enum logic [2:0] {
        LOCK_INIT,
        RESET_CNT,
        TEST_SH,
        SLIP,
        SLIP_WAIT
    } bs_state_t;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/sonic_block_sync.sv
// 66-bit block synchronizer: 10GBASE-R style lock FSM driving gearbox slip
// requests and a block-lock indication, with a 1-cycle registered datapath.
module sonic_block_sync
    import sonic_pcs_pkg::*;
#(
    parameter int unsigned SH_CNT_MAX = 64,
    parameter int unsigned INVLD_MAX  = 16,
    parameter int unsigned SLIP_WAIT  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        xcvr_rx_ready,
    input  logic [65:0] data_in,
    input  logic        data_valid,
    output logic [65:0] data_out,
    output logic        data_out_valid,
    output logic        slip,
    output logic        lock,
    output logic [15:0] lock_loss_cnt
);

    localparam int unsigned SHW = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned IVW = $clog2(INVLD_MAX + 1);
    localparam int unsigned WTW = $clog2(SLIP_WAIT + 1);

    bs_state_t      r_state;
    logic [SHW-1:0] r_sh_cnt;
    logic [IVW-1:0] r_invld_cnt;
    logic [WTW-1:0] r_wait_cnt;
    logic           r_lock;
    logic [15:0]    r_loss_cnt;
    logic [65:0]    r_data;
    logic           r_data_valid;

    bs_state_t      w_state_nxt;
    logic [SHW-1:0] w_sh_nxt;
    logic [IVW-1:0] w_invld_nxt;
    logic [WTW-1:0] w_wait_nxt;
    logic           w_lock_nxt;
    logic           w_loss_evt;
    logic           w_sh_ok;
    logic [SHW-1:0] w_sh_inc;
    logic [IVW-1:0] w_invld_inc;

    assign w_sh_ok     = sh_is_valid(data_in[1:0]);
    assign w_sh_inc    = r_sh_cnt + 1'b1;
    assign w_invld_inc = r_invld_cnt + {{(IVW-1){1'b0}}, ~w_sh_ok};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= LOCK_INIT;
            r_sh_cnt     <= '0;
            r_invld_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_lock       <= 1'b0;
            r_loss_cnt   <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sh_cnt     <= w_sh_nxt;
            r_invld_cnt  <= w_invld_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_lock       <= w_lock_nxt;
            r_data       <= data_in;
            r_data_valid <= data_valid;
            if (w_loss_evt && (r_loss_cnt != '1)) begin
                r_loss_cnt <= r_loss_cnt + 16'd1;
            end
        end
    end

    // The SLIP_WAIT parameter shadows the enum member, so the state is scoped.
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh_cnt;
        w_invld_nxt = r_invld_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_lock_nxt  = r_lock;
        w_loss_evt  = 1'b0;
        if (!xcvr_rx_ready) begin
            w_state_nxt = LOCK_INIT;
            w_lock_nxt  = 1'b0;
            w_loss_evt  = r_lock;
        end else begin
            case (r_state)
                LOCK_INIT: begin
                    w_lock_nxt  = 1'b0;
                    w_state_nxt = RESET_CNT;
                end
                RESET_CNT: begin
                    w_sh_nxt    = '0;
                    w_invld_nxt = '0;
                    w_state_nxt = TEST_SH;
                end
                TEST_SH: begin
                    if (data_valid) begin
                        w_sh_nxt    = w_sh_inc;
                        w_invld_nxt = w_invld_inc;
                        if (!r_lock) begin
                            if (!w_sh_ok) begin
                                w_state_nxt = SLIP;
                            end else if (w_sh_inc == SHW'(SH_CNT_MAX)) begin
                                w_lock_nxt  = 1'b1;
                                w_state_nxt = RESET_CNT;
                            end
                        end else begin
                            if (w_invld_inc == IVW'(INVLD_MAX)) begin
                                w_lock_nxt  = 1'b0;
                                w_loss_evt  = 1'b1;
                                w_state_nxt = SLIP;
                            end else if (w_sh_inc == SHW'(SH_CNT_MAX)) begin
                                w_state_nxt = RESET_CNT;
                            end
                        end
                    end
                end
                SLIP: begin
                    w_lock_nxt  = 1'b0;
                    w_wait_nxt  = WTW'(SLIP_WAIT);
                    w_state_nxt = sonic_pcs_pkg::SLIP_WAIT;
                end
                sonic_pcs_pkg::SLIP_WAIT: begin
                    if (data_valid) begin
                        w_wait_nxt = r_wait_cnt - 1'b1;
                        if (r_wait_cnt <= WTW'(1)) begin
                            w_state_nxt = RESET_CNT;
                        end
                    end
                end
                default: w_state_nxt = LOCK_INIT;
            endcase
        end
    end

    always_comb begin
        slip           = (r_state == SLIP) && xcvr_rx_ready;
        lock           = r_lock;
        lock_loss_cnt  = r_loss_cnt;
        data_out       = r_data;
        data_out_valid = r_data_valid;
    end

endmodule
